rate_tick_gen: RTL and testbench

- Parametrised clock-rate generator for the ALU board. Replaces free-running divided clocks with a single-domain clock-enable tick plus a 50% duty `clk_out` indicator.
- Rates are binary steps (2^k Hz). Selection is by debounced up/down buttons, with saturate or wrap option.
- Adds a single-step mode for manual ALU stepping.
- Downstream logic stays on `clk_in` and qualifies on `tick`.

---
 rtl/rate_tick_gen.sv | 160 ++++++++++++++++
 tb/tb_rate_tick_gen.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rate_tick_gen.sv
// Selectable binary-step rate generator: one clock-enable tick per output period, a 50% duty
// indicator, debounced rate up/down buttons and a manual single-step mode.
module rate_tick_gen #(
    parameter int CLK_HZ       = 50000000,
    parameter int NUM_RATES    = 8,
    parameter int CNT_W        = 28,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int WRAP         = 1,
    localparam int IDX_W       = (NUM_RATES > 1) ? $clog2(NUM_RATES) : 1
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             inc_btn,
    input  logic             dec_btn,
    input  logic             step_btn,
    input  logic             step_mode,
    output logic             tick,
    output logic             clk_out,
    output logic             led,
    output logic [IDX_W-1:0] rate_idx,
    output logic             at_min,
    output logic             at_max
);

    localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_RATES - 1);
    localparam longint HALF_FASTEST = longint'(CLK_HZ) >> NUM_RATES;
    localparam longint HALF_SLOWEST = longint'(CLK_HZ) >> 1;

    if (NUM_RATES < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYC < 1 || HALF_FASTEST < 1 ||
        HALF_SLOWEST > (longint'(1) << CNT_W)) begin : g_bad_params
        $error("rate_tick_gen: parameter set out of range");
    end

    function automatic logic [CNT_W-1:0] half_minus1(input logic [IDX_W-1:0] k);
        longint h;
        h = longint'(CLK_HZ) >> (int'(k) + 1);
        return CNT_W'(h - 1);
    endfunction

    logic [2:0] btn_raw;
    logic [2:0] btn_ev;

    assign btn_raw = {step_btn, dec_btn, inc_btn};

    // Each button: synchroniser, level debounce, then a one-cycle pulse on the accepted rising level.
    for (genvar b = 0; b < 3; b++) begin : g_btn
        logic [SYNC_STAGES-1:0] sync_q;
        logic [DB_W-1:0]        cnt;
        logic                   lvl;
        logic                   lvl_q;
        logic                   ev;
        logic                   s;

        assign s         = sync_q[SYNC_STAGES-1];
        assign btn_ev[b] = ev;

        always_ff @(posedge clk_in) begin
            if (rst) begin
                sync_q <= '0;
                cnt    <= '0;
                lvl    <= 1'b0;
                lvl_q  <= 1'b0;
                ev     <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw[b]};
                if (s != lvl) begin
                    if (cnt == DB_LAST) begin
                        lvl <= s;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    cnt <= '0;
                end
                lvl_q <= lvl;
                ev    <= lvl & ~lvl_q;
            end
        end
    end

    logic             inc_ev;
    logic             dec_ev;
    logic             step_ev;
    logic [IDX_W-1:0] rate_nxt;
    logic             rate_chg;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] half_m1;
    logic             clk_out_q;
    logic             tick_nxt;

    assign inc_ev  = btn_ev[0];
    assign dec_ev  = btn_ev[1];
    assign step_ev = btn_ev[2];
    assign half_m1 = half_minus1(rate_idx);

    // Simultaneous inc and dec cancel; a saturated step is not a change and keeps the phase.
    always_comb begin
        rate_nxt = rate_idx;
        rate_chg = 1'b0;
        if (inc_ev && !dec_ev) begin
            if (rate_idx == IDX_MAX) begin
                if (WRAP != 0) begin
                    rate_nxt = '0;
                    rate_chg = 1'b1;
                end
            end else begin
                rate_nxt = rate_idx + 1'b1;
                rate_chg = 1'b1;
            end
        end else if (dec_ev && !inc_ev) begin
            if (rate_idx == '0) begin
                if (WRAP != 0) begin
                    rate_nxt = IDX_MAX;
                    rate_chg = 1'b1;
                end
            end else begin
                rate_nxt = rate_idx - 1'b1;
                rate_chg = 1'b1;
            end
        end
    end

    assign tick_nxt = ((clk_out & ~clk_out_q) | (step_mode & step_ev)) & ~tick;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            period_cnt <= '0;
            clk_out    <= 1'b0;
            clk_out_q  <= 1'b0;
            tick       <= 1'b0;
            led        <= 1'b0;
            rate_idx   <= '0;
            at_min     <= 1'b1;
            at_max     <= 1'b0;
        end else begin
            rate_idx  <= rate_nxt;
            at_min    <= (rate_nxt == '0);
            at_max    <= (rate_nxt == IDX_MAX);
            clk_out_q <= clk_out;
            tick      <= tick_nxt;
            led       <= led ^ tick_nxt;
            if (step_mode) begin
                period_cnt <= '0;
                clk_out    <= 1'b0;
            end else if (rate_chg) begin
                period_cnt <= '0;
            end else if (period_cnt == half_m1) begin
                period_cnt <= '0;
                clk_out    <= ~clk_out;
            end else begin
                period_cnt <= period_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rate_tick_gen.sv
// Bench for rate_tick_gen: a wrapping and a saturating instance share one stimulus stream and are
// checked each cycle against a behavioural model, plus directed timing checks.
module tb_rate_tick_gen;

    localparam int HZ  = 64;
    localparam int NR  = 4;
    localparam int CW  = 8;
    localparam int SYN = 2;
    localparam int DEB = 4;

    logic clk = 1'b0;
    logic rst, inc_btn, dec_btn, step_btn, step_mode;
    logic tick0, clk0, led0, min0, max0;
    logic tick1, clk1, led1, min1, max1;
    logic [1:0] rate0, rate1;

    rate_tick_gen #(.CLK_HZ(HZ), .NUM_RATES(NR), .CNT_W(CW), .SYNC_STAGES(SYN),
                    .DEBOUNCE_CYC(DEB), .WRAP(1)) dut_wrap (
        .clk_in(clk), .rst(rst), .inc_btn(inc_btn), .dec_btn(dec_btn), .step_btn(step_btn),
        .step_mode(step_mode), .tick(tick0), .clk_out(clk0), .led(led0), .rate_idx(rate0),
        .at_min(min0), .at_max(max0));

    rate_tick_gen #(.CLK_HZ(HZ), .NUM_RATES(NR), .CNT_W(CW), .SYNC_STAGES(SYN),
                    .DEBOUNCE_CYC(DEB), .WRAP(0)) dut_sat (
        .clk_in(clk), .rst(rst), .inc_btn(inc_btn), .dec_btn(dec_btn), .step_btn(step_btn),
        .step_mode(step_mode), .tick(tick1), .clk_out(clk1), .led(led1), .rate_idx(rate1),
        .at_min(min1), .at_max(max1));

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail = 0;
    bit   model_valid = 1'b0;
    logic cur_mode = 1'b0;
    int   tick_count0 = 0;
    int   led_changes0 = 0;
    logic prev_led0 = 1'b0;

    logic smp_rst = 1'b0, smp_inc = 1'b0, smp_dec = 1'b0, smp_step = 1'b0, smp_mode = 1'b0;

    bit [SYN-1:0] m_sync [3];
    int m_run [3];
    bit m_last [3];
    bit m_lvl [3];
    int m_rose [3];
    int m_rate [2];
    int m_cnt [2];
    int m_rise [2];
    bit m_clk [2];
    bit m_tick [2];
    bit m_led [2];
    int m_cyc = 0;

    function automatic int half_of(input int k);
        return HZ >> (k + 1);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic i, input logic d, input logic s,
                                 input logic m, input int cycles);
        rst = r; inc_btn = i; dec_btn = d; step_btn = s; step_mode = m;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    // which: 0 = inc, 1 = dec, 2 = step
    task automatic press(input int which, input int hold, input int gap);
        applyStimulus(1'b0, which == 0, which == 1, which == 2, cur_mode, hold);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, cur_mode, gap);
    endtask

    task automatic wait_tick(input string name, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (tick0 !== 1'b1 && n < 300);
        if (tick0 !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s: no tick within %0d cycles, expected one", name, n);
        end
    endtask

    always @(posedge clk) begin
        smp_rst  <= rst;
        smp_inc  <= inc_btn;
        smp_dec  <= dec_btn;
        smp_step <= step_btn;
        smp_mode <= step_mode;
    end

    // Model advances by the posedge just taken, then the DUTs are compared against it.
    always @(negedge clk) begin
        bit [2:0] raw;
        bit inc_e, dec_e, stp_e, s, chg, cand;
        m_cyc++;
        raw = {smp_step, smp_dec, smp_inc};
        if (smp_rst) begin
            for (int b = 0; b < 3; b++) begin
                m_sync[b] = '0; m_run[b] = 0; m_last[b] = 1'b0; m_lvl[b] = 1'b0; m_rose[b] = -100;
            end
            for (int i = 0; i < 2; i++) begin
                m_rate[i] = 0; m_cnt[i] = 0; m_rise[i] = -100;
                m_clk[i] = 1'b0; m_tick[i] = 1'b0; m_led[i] = 1'b0;
            end
            model_valid = 1'b1;
        end else begin
            inc_e = (m_cyc - m_rose[0] == 2);
            dec_e = (m_cyc - m_rose[1] == 2);
            stp_e = (m_cyc - m_rose[2] == 2);
            for (int b = 0; b < 3; b++) begin
                s = m_sync[b][SYN-1];
                m_sync[b] = {m_sync[b][SYN-2:0], raw[b]};
                m_run[b] = (s == m_last[b]) ? m_run[b] + 1 : 1;
                m_last[b] = s;
                if (s != m_lvl[b] && m_run[b] >= DEB) begin
                    m_lvl[b] = s;
                    if (s) m_rose[b] = m_cyc;
                end
            end
            for (int i = 0; i < 2; i++) begin
                chg = 1'b0;
                if (inc_e && !dec_e) begin
                    if (m_rate[i] == NR - 1) begin
                        if (i == 0) begin m_rate[i] = 0; chg = 1'b1; end
                    end else begin
                        m_rate[i]++; chg = 1'b1;
                    end
                end else if (dec_e && !inc_e) begin
                    if (m_rate[i] == 0) begin
                        if (i == 0) begin m_rate[i] = NR - 1; chg = 1'b1; end
                    end else begin
                        m_rate[i]--; chg = 1'b1;
                    end
                end
                cand = (m_rise[i] == m_cyc - 1) || (smp_mode && stp_e);
                if (smp_mode) begin
                    m_cnt[i] = 0; m_clk[i] = 1'b0;
                end else if (chg) begin
                    m_cnt[i] = 0;
                end else begin
                    m_cnt[i]++;
                    if (m_cnt[i] == half_of(m_rate[i])) begin
                        m_cnt[i] = 0;
                        m_clk[i] = !m_clk[i];
                        if (m_clk[i]) m_rise[i] = m_cyc;
                    end
                end
                m_tick[i] = cand && !m_tick[i];
                if (m_tick[i]) m_led[i] = !m_led[i];
            end
        end
        if (model_valid) begin
            checkOutput("wrap_tick", tick0, m_tick[0]);
            checkOutput("wrap_clk_out", clk0, m_clk[0]);
            checkOutput("wrap_led", led0, m_led[0]);
            checkOutput("wrap_rate_idx", rate0, m_rate[0]);
            checkOutput("wrap_at_min", min0, m_rate[0] == 0);
            checkOutput("wrap_at_max", max0, m_rate[0] == NR - 1);
            checkOutput("sat_tick", tick1, m_tick[1]);
            checkOutput("sat_clk_out", clk1, m_clk[1]);
            checkOutput("sat_led", led1, m_led[1]);
            checkOutput("sat_rate_idx", rate1, m_rate[1]);
            checkOutput("sat_at_min", min1, m_rate[1] == 0);
            checkOutput("sat_at_max", max1, m_rate[1] == NR - 1);
            if (tick0 === 1'b1) tick_count0++;
            if (led0 !== prev_led0) led_changes0++;
            prev_led0 = led0;
        end
    end

    initial begin
        #200000;
        n_fail++;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int n, t0, l0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        checkOutput("reset_tick", tick0, 0);
        checkOutput("reset_clk_out", clk0, 0);
        checkOutput("reset_led", led0, 0);
        checkOutput("reset_rate_idx", rate0, 0);
        checkOutput("reset_at_min", min0, 1);
        checkOutput("reset_at_max", max0, 0);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        wait_tick("first_tick", n);
        checkOutput("first_tick_latency", n, 33);
        wait_tick("run_period0", n);
        checkOutput("tick_spacing_rate0", n, 64);

        // inc held 10 cycles: sampled first at the next edge, accepted 7 edges later
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7);
        checkOutput("inc_not_yet", rate0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        checkOutput("inc_latency_7", rate0, 1);
        checkOutput("inc_at_min_clear", min0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20);
        checkOutput("release_no_event", rate0, 1);
        wait_tick("sync_rate1", n);
        wait_tick("run_period1", n);
        checkOutput("tick_spacing_rate1", n, 32);

        press(0, 6, 12);
        checkOutput("inc_to_2", rate0, 2);
        press(0, 6, 12);
        checkOutput("inc_to_3", rate0, 3);
        checkOutput("at_max_3", max0, 1);
        wait_tick("sync_rate3", n);
        wait_tick("run_period3", n);
        checkOutput("tick_spacing_rate3", n, 8);
        press(0, 6, 12);
        checkOutput("inc_wrap_to_0", rate0, 0);
        checkOutput("wrap_at_min", min0, 1);
        checkOutput("sat_hold_at_3", rate1, 3);
        checkOutput("sat_at_max", max1, 1);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20);
        checkOutput("glitch_no_change_wrap", rate0, 0);
        checkOutput("glitch_no_change_sat", rate1, 3);

        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20);
        checkOutput("inc_dec_same_wrap", rate0, 0);
        checkOutput("inc_dec_same_sat", rate1, 3);

        press(1, 6, 12);
        checkOutput("dec_wrap_to_max", rate0, 3);
        checkOutput("dec_sat_from_max", rate1, 2);
        press(1, 6, 12);
        checkOutput("dec_to_2", rate0, 2);
        checkOutput("dec_sat_to_1", rate1, 1);

        press(2, 6, 12);

        cur_mode = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5);
        t0 = tick_count0;
        l0 = led_changes0;
        press(2, 6, 12);
        press(2, 6, 12);
        press(2, 6, 12);
        checkOutput("step_tick_count", tick_count0 - t0, 3);
        checkOutput("step_led_toggles", led_changes0 - l0, 3);
        checkOutput("step_clk_out_low", clk0, 0);

        cur_mode = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        wait_tick("step_exit", n);
        checkOutput("step_exit_first_tick", n, 9);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        checkOutput("midrst_rate_idx", rate0, 0);
        checkOutput("midrst_clk_out", clk0, 0);
        checkOutput("midrst_tick", tick0, 0);
        checkOutput("midrst_led", led0, 0);
        checkOutput("midrst_at_min", min0, 1);
        checkOutput("midrst_sat_rate", rate1, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        wait_tick("post_rst_first", n);
        checkOutput("post_rst_first_tick", n, 33);
        wait_tick("post_rst_period", n);
        checkOutput("post_rst_spacing", n, 64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
